// File: rtl/dtc_walk_if.sv
// dtc_walk_if: config, feature-in and class-out handshakes of the decision-tree walk engine.
interface dtc_walk_if #(
    parameter int N_FEAT  = 12,
    parameter int CLASS_W = 3,
    parameter int NODE_AW = 6,
    parameter int FIDX_W  = $clog2(N_FEAT),
    parameter int ENTRY_W = 1 + FIDX_W + 2 * NODE_AW + CLASS_W
);
    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [ENTRY_W-1:0] cfg_wdata;
    logic               cfg_ready;
    logic               in_valid;
    logic               in_ready;
    logic [N_FEAT-1:0]  inp;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] outp;
    logic               out_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
        input  cfg_ready, in_ready, out_valid, outp, out_err
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, in_valid, inp, out_ready,
        output cfg_ready, in_ready, out_valid, outp, out_err
    );
endinterface

// File: rtl/dtc_walk_engine.sv
// dtc_walk_engine: programmable decision-tree classifier walking one node-table entry per clock.
module dtc_walk_engine #(
    parameter int N_FEAT    = 12,
    parameter int CLASS_W   = 3,
    parameter int NODE_AW   = 6,
    parameter int MAX_DEPTH = 16,
    parameter int ERR_CLASS = 0
) (
    input logic       clk,
    input logic       rst_n,
    dtc_walk_if.slave bus
);
    localparam int FIDX_W  = $clog2(N_FEAT);
    localparam int ENTRY_W = 1 + FIDX_W + 2 * NODE_AW + CLASS_W;
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
    state_t state, state_nx;

    logic [ENTRY_W-1:0] tbl [2**NODE_AW];
    logic [N_FEAT-1:0]  vec;
    logic [NODE_AW-1:0] cur;
    logic [DEPTH_W-1:0] depth;
    logic [CLASS_W-1:0] res;
    logic               err;
    logic               idle;

    // Entry layout {is_leaf, feat_idx, child1, child0, class}
    logic [ENTRY_W-1:0] e;
    logic               leaf, bad, lim, fin;
    logic [FIDX_W-1:0]  fidx;
    logic [NODE_AW-1:0] c1, c0;
    logic [CLASS_W-1:0] cls;
    assign e    = tbl[cur];
    assign leaf = e[ENTRY_W-1];
    assign fidx = e[ENTRY_W-2 -: FIDX_W];
    assign c1   = e[CLASS_W+NODE_AW +: NODE_AW];
    assign c0   = e[CLASS_W +: NODE_AW];
    assign cls  = e[CLASS_W-1:0];
    assign bad  = !leaf && (32'(fidx) >= N_FEAT);
    assign lim  = depth == DEPTH_W'(MAX_DEPTH - 1);
    assign fin  = leaf || bad || lim;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? WALK : IDLE;
            WALK:    state_nx = fin ? DONE : WALK;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        idle          = state == IDLE;
        bus.in_ready  = idle;
        bus.cfg_ready = idle;
        bus.out_valid = state == DONE;
        bus.outp      = res;
        bus.out_err   = err;
    end

    // A write and an accept in the same cycle both land; the walk reads the table from the next cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**NODE_AW; i++) tbl[i] <= '0;
            vec   <= '0;
            cur   <= '0;
            depth <= '0;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            if (bus.cfg_we && idle) tbl[bus.cfg_addr] <= bus.cfg_wdata;
            if (bus.in_valid && idle) begin
                vec   <= bus.inp;
                cur   <= '0;
                depth <= '0;
            end
            if (state == WALK) begin
                if (fin) begin
                    res <= leaf ? cls : CLASS_W'(ERR_CLASS);
                    err <= !leaf;
                end else begin
                    cur   <= vec[fidx] ? c1 : c0;
                    depth <= depth + 1'b1;
                end
            end
        end
    end
endmodule
